rs_issue_ctrl: RTL and testbench

//  Slot-allocation and issue scheduler for the ALU reservation station (RS).

---
 rtl/rs_issue_ctrl.sv | 174 +++++++++++++++++
 tb/tb_rs_issue_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rs_issue_ctrl.sv
// rtl/rs_issue_ctrl.sv - ALU reservation-station slot allocator and round-robin issue scheduler
// Optional RS_ISSUE_STATS_EN adds 32-bit issued-op and full-stall counters.
module rs_issue_ctrl #(
  parameter int RS_SIZE  = 16,
  parameter int RS_IDX_W = 4
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                clr_in,
  input  logic                alloc_req_in,
  input  logic                alloc_rdy_in,
  output logic [RS_IDX_W-1:0] free_pos_out,
  output logic                full_out,
  input  logic                wake_in,
  input  logic [RS_IDX_W-1:0] wake_idx_in,
  output logic                issue_vld_out,
  output logic [RS_IDX_W-1:0] issue_idx_out,
  input  logic                issue_ack_in,
  output logic [RS_IDX_W:0]   cnt_out,
  output logic [31:0]         issue_cnt_out,
  output logic [31:0]         stall_cnt_out
);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t              r_state, w_state_nxt;
  logic [RS_SIZE-1:0]  r_busy, r_ready, r_issued;
  logic [RS_IDX_W-1:0] r_rr_ptr, r_issue_idx;
  logic                r_issue_vld;
  logic [RS_IDX_W:0]   r_cnt;

  logic [RS_SIZE-1:0]  w_busy_nxt, w_ready_nxt, w_issued_nxt, w_cand;
  logic [RS_IDX_W-1:0] w_rr_nxt, w_idx_nxt, w_free_pos, w_scan_ptr, w_scan_idx, w_pick;
  logic                w_vld_nxt, w_full, w_pick_found;
  logic                w_alloc_acc, w_ack_acc, w_wake_acc;
  logic [RS_IDX_W:0]   w_cnt_nxt;

  // Lowest-index free slot; stays 0 when every entry is busy.
  always_comb begin
    w_free_pos = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!r_busy[i]) w_free_pos = RS_IDX_W'(i);
    end
  end

  assign w_full      = &r_busy;
  assign w_alloc_acc = alloc_req_in && !w_full;
  assign w_ack_acc   = (r_state == S_HOLD) && issue_ack_in;
  assign w_wake_acc  = wake_in && r_busy[wake_idx_in] && !r_issued[wake_idx_in];

  // On ack the scan restarts just past the retiring entry, which is excluded.
  always_comb begin
    w_cand = r_busy & r_ready & ~r_issued;
    if (w_ack_acc) w_cand[r_issue_idx] = 1'b0;
  end

  assign w_scan_ptr = w_ack_acc ? (r_issue_idx + RS_IDX_W'(1)) : r_rr_ptr;

  always_comb begin
    w_pick       = '0;
    w_pick_found = 1'b0;
    w_scan_idx   = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      w_scan_idx = w_scan_ptr + RS_IDX_W'(i);
      if (!w_pick_found && w_cand[w_scan_idx]) begin
        w_pick       = w_scan_idx;
        w_pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_busy_nxt   = r_busy;
    w_ready_nxt  = r_ready;
    w_issued_nxt = r_issued;
    w_rr_nxt     = r_rr_ptr;
    w_vld_nxt    = r_issue_vld;
    w_idx_nxt    = r_issue_idx;

    if (w_wake_acc) w_ready_nxt[wake_idx_in] = 1'b1;
    if (w_alloc_acc) begin
      w_busy_nxt[w_free_pos]  = 1'b1;
      w_ready_nxt[w_free_pos] = alloc_rdy_in;
    end

    case (r_state)
      S_IDLE: begin
        if (w_pick_found) begin
          w_idx_nxt            = w_pick;
          w_vld_nxt            = 1'b1;
          w_issued_nxt[w_pick] = 1'b1;
          w_state_nxt          = S_HOLD;
        end
      end
      S_HOLD: begin
        if (issue_ack_in) begin
          w_busy_nxt[r_issue_idx]   = 1'b0;
          w_ready_nxt[r_issue_idx]  = 1'b0;
          w_issued_nxt[r_issue_idx] = 1'b0;
          w_rr_nxt                  = w_scan_ptr;
          if (w_pick_found) begin
            w_idx_nxt            = w_pick;
            w_issued_nxt[w_pick] = 1'b1;
          end else begin
            w_vld_nxt   = 1'b0;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_cnt_nxt = r_cnt + (RS_IDX_W + 1)'(w_alloc_acc) - (RS_IDX_W + 1)'(w_ack_acc);

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state     <= S_IDLE;
      r_busy      <= '0;
      r_ready     <= '0;
      r_issued    <= '0;
      r_rr_ptr    <= '0;
      r_issue_vld <= 1'b0;
      r_issue_idx <= '0;
      r_cnt       <= '0;
    end else if (clr_in) begin
      r_state     <= S_IDLE;
      r_busy      <= '0;
      r_ready     <= '0;
      r_issued    <= '0;
      r_rr_ptr    <= '0;
      r_issue_vld <= 1'b0;
      r_cnt       <= '0;
    end else if (rdy_in) begin
      r_state     <= w_state_nxt;
      r_busy      <= w_busy_nxt;
      r_ready     <= w_ready_nxt;
      r_issued    <= w_issued_nxt;
      r_rr_ptr    <= w_rr_nxt;
      r_issue_vld <= w_vld_nxt;
      r_issue_idx <= w_idx_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  assign free_pos_out  = w_free_pos;
  assign full_out      = w_full;
  assign issue_vld_out = r_issue_vld;
  assign issue_idx_out = r_issue_idx;
  assign cnt_out       = r_cnt;

`ifdef RS_ISSUE_STATS_EN
  logic [31:0] r_issue_cnt, r_stall_cnt;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_issue_cnt <= '0;
      r_stall_cnt <= '0;
    end else if (rdy_in && !clr_in) begin
      if (w_ack_acc)              r_issue_cnt <= r_issue_cnt + 32'd1;
      if (alloc_req_in && w_full) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign issue_cnt_out = r_issue_cnt;
  assign stall_cnt_out = r_stall_cnt;
`else
  assign issue_cnt_out = 32'd0;
  assign stall_cnt_out = 32'd0;
`endif

endmodule

// File: tb/tb_rs_issue_ctrl.sv
// tb/tb_rs_issue_ctrl.sv - directed self-checking bench for rs_issue_ctrl
// Stats expectations follow RS_ISSUE_STATS_EN when it is defined for the build.
module tb_rs_issue_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clr_in;
  logic        alloc_req_in, alloc_rdy_in;
  logic [3:0]  free_pos_out;
  logic        full_out;
  logic        wake_in;
  logic [3:0]  wake_idx_in;
  logic        issue_vld_out;
  logic [3:0]  issue_idx_out;
  logic        issue_ack_in;
  logic [4:0]  cnt_out;
  logic [31:0] issue_cnt_out, stall_cnt_out;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk_in = ~clk_in;

  rs_issue_ctrl #(.RS_SIZE(16), .RS_IDX_W(4)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .clr_in        (clr_in),
    .alloc_req_in  (alloc_req_in),
    .alloc_rdy_in  (alloc_rdy_in),
    .free_pos_out  (free_pos_out),
    .full_out      (full_out),
    .wake_in       (wake_in),
    .wake_idx_in   (wake_idx_in),
    .issue_vld_out (issue_vld_out),
    .issue_idx_out (issue_idx_out),
    .issue_ack_in  (issue_ack_in),
    .cnt_out       (cnt_out),
    .issue_cnt_out (issue_cnt_out),
    .stall_cnt_out (stall_cnt_out)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    rst_in = 1'b0; rdy_in = 1'b1; clr_in = 1'b0;
    alloc_req_in = 1'b0; alloc_rdy_in = 1'b0;
    wake_in = 1'b0; wake_idx_in = 4'd0; issue_ack_in = 1'b0;
    step(); step();
    n_chk++; if (issue_vld_out !== 1'b0) $display("FAIL rst_vld: got %0b exp 0", issue_vld_out); else n_pass++;
    n_chk++; if (cnt_out !== 5'd0) $display("FAIL rst_cnt: got %0d exp 0", cnt_out); else n_pass++;
    n_chk++; if (free_pos_out !== 4'd0) $display("FAIL rst_free_pos: got %0d exp 0", free_pos_out); else n_pass++;
    n_chk++; if (full_out !== 1'b0) $display("FAIL rst_full: got %0b exp 0", full_out); else n_pass++;
    n_chk++; if (issue_cnt_out !== 32'd0 || stall_cnt_out !== 32'd0)
      $display("FAIL rst_stats: got %0d/%0d exp 0/0", issue_cnt_out, stall_cnt_out); else n_pass++;
    rst_in = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    alloc_req_in = 1'b1; alloc_rdy_in = 1'b1; issue_ack_in = 1'b1;
    step();
    n_chk++; if (free_pos_out !== 4'd1 || cnt_out !== 5'd1 || issue_vld_out !== 1'b0)
      $display("FAIL b2b_alloc0: got pos=%0d cnt=%0d vld=%0b exp 1/1/0", free_pos_out, cnt_out, issue_vld_out); else n_pass++;
    step();
    n_chk++; if (issue_vld_out !== 1'b1 || issue_idx_out !== 4'd0 || cnt_out !== 5'd2)
      $display("FAIL b2b_issue0: got vld=%0b idx=%0d cnt=%0d exp 1/0/2", issue_vld_out, issue_idx_out, cnt_out); else n_pass++;
    step();
    alloc_req_in = 1'b0;
    n_chk++; if (issue_vld_out !== 1'b1 || issue_idx_out !== 4'd1 || cnt_out !== 5'd2)
      $display("FAIL b2b_issue1: got vld=%0b idx=%0d cnt=%0d exp 1/1/2", issue_vld_out, issue_idx_out, cnt_out); else n_pass++;
    step();
    n_chk++; if (issue_vld_out !== 1'b1 || issue_idx_out !== 4'd2 || cnt_out !== 5'd1)
      $display("FAIL b2b_issue2: got vld=%0b idx=%0d cnt=%0d exp 1/2/1", issue_vld_out, issue_idx_out, cnt_out); else n_pass++;
    step();
    issue_ack_in = 1'b0;
    n_chk++; if (issue_vld_out !== 1'b0 || cnt_out !== 5'd0)
      $display("FAIL b2b_drain: got vld=%0b cnt=%0d exp 0/0", issue_vld_out, cnt_out); else n_pass++;
`ifdef RS_ISSUE_STATS_EN
    n_chk++; if (issue_cnt_out !== 32'd3) $display("FAIL b2b_issue_cnt: got %0d exp 3", issue_cnt_out); else n_pass++;
`else
    n_chk++; if (issue_cnt_out !== 32'd0) $display("FAIL b2b_issue_cnt: got %0d exp 0", issue_cnt_out); else n_pass++;
`endif
  endtask

  task automatic test_wakeup();
    alloc_req_in = 1'b1; alloc_rdy_in = 1'b0;
    step();
    alloc_req_in = 1'b0;
    step();
    n_chk++; if (issue_vld_out !== 1'b0 || cnt_out !== 5'd1)
      $display("FAIL wake_not_ready: got vld=%0b cnt=%0d exp 0/1", issue_vld_out, cnt_out); else n_pass++;
    wake_in = 1'b1; wake_idx_in = 4'd0;
    step();
    wake_in = 1'b0;
    n_chk++; if (issue_vld_out !== 1'b0) $display("FAIL wake_latency: got vld=%0b exp 0", issue_vld_out); else n_pass++;
    step();
    n_chk++; if (issue_vld_out !== 1'b1 || issue_idx_out !== 4'd0)
      $display("FAIL wake_issue: got vld=%0b idx=%0d exp 1/0", issue_vld_out, issue_idx_out); else n_pass++;
    issue_ack_in = 1'b1;
    step();
    issue_ack_in = 1'b0;
    wake_in = 1'b1; wake_idx_in = 4'd5;
    step();
    wake_in = 1'b0;
    step(); step();
    n_chk++; if (issue_vld_out !== 1'b0 || cnt_out !== 5'd0)
      $display("FAIL wake_nonbusy: got vld=%0b cnt=%0d exp 0/0", issue_vld_out, cnt_out); else n_pass++;
  endtask

  task automatic test_full();
    alloc_req_in = 1'b1; alloc_rdy_in = 1'b0;
    for (int i = 0; i < 16; i++) step();
    n_chk++; if (full_out !== 1'b1 || cnt_out !== 5'd16 || free_pos_out !== 4'd0)
      $display("FAIL full_fill: got full=%0b cnt=%0d pos=%0d exp 1/16/0", full_out, cnt_out, free_pos_out); else n_pass++;
    for (int i = 0; i < 4; i++) step();
    alloc_req_in = 1'b0;
    n_chk++; if (cnt_out !== 5'd16) $display("FAIL full_ignore: got cnt=%0d exp 16", cnt_out); else n_pass++;
`ifdef RS_ISSUE_STATS_EN
    n_chk++; if (stall_cnt_out !== 32'd4) $display("FAIL full_stall_cnt: got %0d exp 4", stall_cnt_out); else n_pass++;
`else
    n_chk++; if (stall_cnt_out !== 32'd0) $display("FAIL full_stall_cnt: got %0d exp 0", stall_cnt_out); else n_pass++;
`endif
    wake_in = 1'b1; wake_idx_in = 4'd7;
    step();
    wake_in = 1'b0;
    step();
    n_chk++; if (issue_vld_out !== 1'b1 || issue_idx_out !== 4'd7)
      $display("FAIL full_issue7: got vld=%0b idx=%0d exp 1/7", issue_vld_out, issue_idx_out); else n_pass++;
    issue_ack_in = 1'b1;
    #1;
    n_chk++; if (full_out !== 1'b1) $display("FAIL full_ack_cycle: got full=%0b exp 1", full_out); else n_pass++;
    step();
    issue_ack_in = 1'b0;
    n_chk++; if (full_out !== 1'b0 || free_pos_out !== 4'd7 || cnt_out !== 5'd15)
      $display("FAIL full_after_ack: got full=%0b pos=%0d cnt=%0d exp 0/7/15", full_out, free_pos_out, cnt_out); else n_pass++;
  endtask

  task automatic test_rr_wrap();
    clr_in = 1'b1;
    step();
    clr_in = 1'b0;
    n_chk++; if (cnt_out !== 5'd0 || issue_vld_out !== 1'b0)
      $display("FAIL rr_clr: got cnt=%0d vld=%0b exp 0/0", cnt_out, issue_vld_out); else n_pass++;
    alloc_req_in = 1'b1; alloc_rdy_in = 1'b0;
    for (int i = 0; i < 16; i++) step();
    alloc_req_in = 1'b0;
    wake_in = 1'b1; wake_idx_in = 4'd14;
    step();
    wake_idx_in = 4'd15;
    step();
    n_chk++; if (issue_vld_out !== 1'b1 || issue_idx_out !== 4'd14)
      $display("FAIL rr_issue14: got vld=%0b idx=%0d exp 1/14", issue_vld_out, issue_idx_out); else n_pass++;
    wake_idx_in = 4'd2;
    step();
    wake_in = 1'b0;
    issue_ack_in = 1'b1;
    step();
    issue_ack_in = 1'b0;
    n_chk++; if (issue_vld_out !== 1'b1 || issue_idx_out !== 4'd15)
      $display("FAIL rr_issue15: got vld=%0b idx=%0d exp 1/15", issue_vld_out, issue_idx_out); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      step();
      n_chk++; if (issue_vld_out !== 1'b1 || issue_idx_out !== 4'd15)
        $display("FAIL rr_hold%0d: got vld=%0b idx=%0d exp 1/15", i, issue_vld_out, issue_idx_out); else n_pass++;
    end
    issue_ack_in = 1'b1;
    step();
    n_chk++; if (issue_vld_out !== 1'b1 || issue_idx_out !== 4'd2)
      $display("FAIL rr_wrap2: got vld=%0b idx=%0d exp 1/2", issue_vld_out, issue_idx_out); else n_pass++;
    step();
    issue_ack_in = 1'b0;
    n_chk++; if (issue_vld_out !== 1'b0 || cnt_out !== 5'd13)
      $display("FAIL rr_drain: got vld=%0b cnt=%0d exp 0/13", issue_vld_out, cnt_out); else n_pass++;
  endtask

  task automatic test_clr_and_freeze();
    wake_in = 1'b1; wake_idx_in = 4'd0;
    step();
    wake_in = 1'b0;
    step();
    n_chk++; if (issue_vld_out !== 1'b1 || issue_idx_out !== 4'd0)
      $display("FAIL clr_pre_issue: got vld=%0b idx=%0d exp 1/0", issue_vld_out, issue_idx_out); else n_pass++;
    clr_in = 1'b1; issue_ack_in = 1'b1; alloc_req_in = 1'b1; alloc_rdy_in = 1'b1;
    step();
    clr_in = 1'b0; issue_ack_in = 1'b0; alloc_req_in = 1'b0; alloc_rdy_in = 1'b0;
    n_chk++; if (issue_vld_out !== 1'b0 || cnt_out !== 5'd0 || full_out !== 1'b0 || free_pos_out !== 4'd0)
      $display("FAIL clr_state: got vld=%0b cnt=%0d full=%0b pos=%0d exp 0/0/0/0",
               issue_vld_out, cnt_out, full_out, free_pos_out); else n_pass++;
`ifdef RS_ISSUE_STATS_EN
    n_chk++; if (issue_cnt_out !== 32'd8) $display("FAIL clr_issue_cnt: got %0d exp 8", issue_cnt_out); else n_pass++;
`else
    n_chk++; if (issue_cnt_out !== 32'd0) $display("FAIL clr_issue_cnt: got %0d exp 0", issue_cnt_out); else n_pass++;
`endif
    alloc_req_in = 1'b1;
    step();
    alloc_req_in = 1'b0;
    rdy_in = 1'b0; wake_in = 1'b1; wake_idx_in = 4'd0; alloc_req_in = 1'b1;
    step(); step();
    n_chk++; if (issue_vld_out !== 1'b0 || cnt_out !== 5'd1 || free_pos_out !== 4'd1)
      $display("FAIL freeze: got vld=%0b cnt=%0d pos=%0d exp 0/1/1", issue_vld_out, cnt_out, free_pos_out); else n_pass++;
    rdy_in = 1'b1; wake_in = 1'b0; alloc_req_in = 1'b0;
    step(); step();
    n_chk++; if (issue_vld_out !== 1'b0) $display("FAIL freeze_no_wake: got vld=%0b exp 0", issue_vld_out); else n_pass++;
    wake_in = 1'b1;
    step();
    wake_in = 1'b0;
    step();
    n_chk++; if (issue_vld_out !== 1'b1 || issue_idx_out !== 4'd0)
      $display("FAIL thaw_issue: got vld=%0b idx=%0d exp 1/0", issue_vld_out, issue_idx_out); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_wakeup();
    test_full();
    test_rr_wrap();
    test_clr_and_freeze();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
